// File: rtl/mdio_pkg.sv
// Shared field widths, frame codes and FSM state type for the MDIO PHY-side target.
package mdio_pkg;

   localparam int unsigned PHYAD_W    = 5;
   localparam int unsigned REGAD_W    = 5;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned FRAME_BITS = 32;

   localparam logic [1:0] ST_CODE  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   typedef enum logic [3:0] {
      StIdle,
      StSt,
      StOp,
      StPhyad,
      StRegad,
      StTa,
      StWdata,
      StRdata,
      StSkip
   } mdio_state_e;

endpackage

// File: rtl/mdio_edge_det.sv
// MDC rising-edge detector plus a register holding the bit sampled on the previous MDC edge.
module mdio_edge_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic mdc_i,
   input  logic mdio_i,
   output logic rise_o,
   output logic prev_bit_o
);

   logic mdc_q;
   logic bit_q;

   assign rise_o     = mdc_i & ~mdc_q;
   assign prev_bit_o = bit_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mdc_q <= 1'b0;
         bit_q <= 1'b0;
      end else begin
         mdc_q <= mdc_i;
         if (rise_o) begin
            bit_q <= mdio_i;
         end
      end
   end

endmodule

// File: rtl/mdio_phy_target.sv
// MDIO (clause 22, no preamble) PHY-side target: decodes 32-bit frames into register
// write/read strobes and serialises read data back to the master.
module mdio_phy_target
   import mdio_pkg::*;
#(
   parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'd1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               MDC,
   input  logic               MDIO_OE,
   input  logic               MDIO_OUT,
   output logic               MDIO_IN,
   output logic               MDIO_IN_OE,
   output logic [REGAD_W-1:0] REG_ADDR,
   output logic [DATA_W-1:0]  WR_DATA,
   output logic               WR_STB,
   output logic               RD_STB,
   input  logic [DATA_W-1:0]  RD_DATA,
   output logic               FRAME_ERR
);

   logic              mdc_rise;
   logic              prev_bit;
   logic              oe_checked;
   logic [1:0]        pair;
   mdio_state_e       state_q;
   logic [3:0]        cnt_q;
   logic [4:0]        pos_q;
   logic [DATA_W-1:0] sh_q;
   logic              is_read_q;

   mdio_edge_det u_edge_det (
      .clk_i      (CLK),
      .rst_ni     (RESET),
      .mdc_i      (MDC),
      .mdio_i     (MDIO_OUT),
      .rise_o     (mdc_rise),
      .prev_bit_o (prev_bit)
   );

   assign pair = {prev_bit, MDIO_OUT};
   // The master must hold the line through the header and write data; TA, SKIP and RDATA don't care.
   assign oe_checked = state_q inside {StSt, StOp, StPhyad, StRegad, StWdata};

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         pos_q      <= 5'd0;
         sh_q       <= '0;
         is_read_q  <= 1'b0;
         MDIO_IN    <= 1'b0;
         MDIO_IN_OE <= 1'b0;
         REG_ADDR   <= '0;
         WR_DATA    <= '0;
         WR_STB     <= 1'b0;
         RD_STB     <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         WR_STB    <= 1'b0;
         RD_STB    <= 1'b0;
         FRAME_ERR <= 1'b0;
         // MDC edges are at least two CLKs apart, so this never collides with a shift.
         if (RD_STB) begin
            sh_q <= RD_DATA;
         end
         if (mdc_rise) begin
            cnt_q <= cnt_q + 4'd1;
            pos_q <= pos_q + 5'd1;
            if (oe_checked && !MDIO_OE) begin
               FRAME_ERR <= 1'b1;
               state_q   <= StIdle;
            end else begin
               unique case (state_q)
                  StIdle: begin
                     if (MDIO_OE) begin
                        state_q <= StSt;
                        cnt_q   <= 4'd0;
                        pos_q   <= 5'd1;
                     end
                  end
                  StSt: begin
                     cnt_q <= 4'd0;
                     if (pair == ST_CODE) begin
                        state_q <= StOp;
                     end else begin
                        FRAME_ERR <= 1'b1;
                        state_q   <= StIdle;
                     end
                  end
                  StOp: begin
                     if (cnt_q == 4'd1) begin
                        cnt_q     <= 4'd0;
                        is_read_q <= (pair == OP_READ);
                        if (pair == OP_WRITE || pair == OP_READ) begin
                           state_q <= StPhyad;
                        end else begin
                           FRAME_ERR <= 1'b1;
                           state_q   <= StSkip;
                        end
                     end
                  end
                  StPhyad: begin
                     sh_q <= {sh_q[DATA_W-2:0], MDIO_OUT};
                     if (cnt_q == 4'd4) begin
                        cnt_q   <= 4'd0;
                        state_q <= StRegad;
                     end
                  end
                  StRegad: begin
                     sh_q <= {sh_q[DATA_W-2:0], MDIO_OUT};
                     if (cnt_q == 4'd4) begin
                        cnt_q <= 4'd0;
                        // sh_q[8:4] holds PHYAD, sh_q[3:0] the first four REGAD bits.
                        if (sh_q[8:4] == PHY_ADDR) begin
                           REG_ADDR <= {sh_q[3:0], MDIO_OUT};
                           RD_STB   <= is_read_q;
                           state_q  <= StTa;
                        end else begin
                           state_q <= StSkip;
                        end
                     end
                  end
                  StTa: begin
                     if (cnt_q == 4'd1) begin
                        cnt_q <= 4'd0;
                        if (is_read_q) begin
                           MDIO_IN_OE <= 1'b1;
                           MDIO_IN    <= sh_q[DATA_W-1];
                           state_q    <= StRdata;
                        end else begin
                           state_q <= StWdata;
                        end
                     end
                  end
                  StWdata: begin
                     sh_q <= {sh_q[DATA_W-2:0], MDIO_OUT};
                     if (cnt_q == 4'd15) begin
                        WR_DATA <= {sh_q[DATA_W-2:0], MDIO_OUT};
                        WR_STB  <= 1'b1;
                        state_q <= StIdle;
                     end
                  end
                  StRdata: begin
                     if (cnt_q == 4'd15) begin
                        MDIO_IN_OE <= 1'b0;
                        MDIO_IN    <= 1'b0;
                        state_q    <= StIdle;
                     end else begin
                        MDIO_IN <= sh_q[DATA_W-2];
                        sh_q    <= {sh_q[DATA_W-2:0], 1'b0};
                     end
                  end
                  StSkip: begin
                     if (pos_q == 5'(FRAME_BITS - 1)) begin
                        state_q <= StIdle;
                     end
                  end
                  default: state_q <= StIdle;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_mdio_phy_target.sv
// Self-checking bench for mdio_phy_target: frame-level reference model, per-cycle compare,
// directed literal cases and randomized frames.
module tb_mdio_phy_target;

   localparam logic [4:0] PHY = 5'd1;

   logic        CLK = 1'b0;
   logic        RESET, MDC, MDIO_OE, MDIO_OUT;
   logic [15:0] RD_DATA;
   logic        MDIO_IN, MDIO_IN_OE, WR_STB, RD_STB, FRAME_ERR;
   logic [4:0]  REG_ADDR;
   logic [15:0] WR_DATA;

   mdio_phy_target #(.PHY_ADDR(PHY)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .MDC        (MDC),
      .MDIO_OE    (MDIO_OE),
      .MDIO_OUT   (MDIO_OUT),
      .MDIO_IN    (MDIO_IN),
      .MDIO_IN_OE (MDIO_IN_OE),
      .REG_ADDR   (REG_ADDR),
      .WR_DATA    (WR_DATA),
      .WR_STB     (WR_STB),
      .RD_STB     (RD_STB),
      .RD_DATA    (RD_DATA),
      .FRAME_ERR  (FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;

   // Expected DUT outputs for the current CLK, maintained by the frame model.
   logic        e_in, e_oe, e_wr, e_rd, e_err;
   logic [4:0]  e_reg;
   logic [15:0] e_wdata;
   logic        chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (chk_en) begin
         check("MDIO_IN", 32'(MDIO_IN), 32'(e_in));
         check("MDIO_IN_OE", 32'(MDIO_IN_OE), 32'(e_oe));
         check("WR_STB", 32'(WR_STB), 32'(e_wr));
         check("RD_STB", 32'(RD_STB), 32'(e_rd));
         check("FRAME_ERR", 32'(FRAME_ERR), 32'(e_err));
         check("REG_ADDR", 32'(REG_ADDR), 32'(e_reg));
         check("WR_DATA", 32'(WR_DATA), 32'(e_wdata));
      end
   end

   // Event monitor used by the directed literal checks.
   int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_bits = 0, oe_cyc = 0;
   logic [15:0] last_wd = '0;
   logic [15:0] ser = '0;
   logic        mdc_m = 1'b0;

   always @(negedge CLK) begin
      if (WR_STB) begin
         wr_cnt++;
         last_wd = WR_DATA;
      end
      if (RD_STB) rd_cnt++;
      if (FRAME_ERR) err_cnt++;
      if (MDIO_IN_OE) oe_cyc++;
      if (MDC && !mdc_m && MDIO_IN_OE) begin
         oe_bits++;
         ser = {ser[14:0], MDIO_IN};
      end
      mdc_m = MDC;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      e_wr  = 1'b0;
      e_rd  = 1'b0;
      e_err = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #2;
      RESET = 1'b0;
      MDC = 1'b0; MDIO_OE = 1'b0; MDIO_OUT = 1'b0;
      e_in = 1'b0; e_oe = 1'b0; e_wr = 1'b0; e_rd = 1'b0; e_err = 1'b0;
      e_reg = '0; e_wdata = '0;
      @(posedge CLK);
      #2;
      RESET = 1'b1;
      tick();
   endtask

   task automatic idle_edge();
      MDIO_OE  = 1'b0;
      MDIO_OUT = 1'($urandom);
      tick();
      MDC = 1'b1;
      tick();
      MDC = 1'b0;
   endtask

   // Drives one frame MSB first. OE is released from edge 'drop' on (32 = never);
   // reset is pulsed instead of edge 'rst_at' (-1 = never).
   task automatic send_frame(input logic [31:0] w, input int drop, input logic [15:0] rd,
                             input int rst_at);
      logic st_ok, is_wr, is_rd, match, upd;
      int   len, last_chk, err_at, rd_at, wr_at, abort_at, lo_n, hi_n;
      st_ok  = (w[31:30] == 2'b01);
      is_wr  = (w[29:28] == 2'b01);
      is_rd  = (w[29:28] == 2'b10);
      match  = (w[27:23] == PHY);
      err_at = -1; rd_at = -1; wr_at = -1; abort_at = -1; len = 32;
      if (!st_ok) begin
         len = 2; err_at = 1; last_chk = 1;
      end else if (!(is_wr || is_rd)) begin
         err_at = 3; last_chk = 3;
      end else if (is_wr && match) begin
         last_chk = 31;
      end else begin
         last_chk = 13;
      end
      // Line release is only an error on header or write-data bits (not on the TA pair).
      for (int k = drop; k <= last_chk; k++) begin
         if (k >= 1 && k != 14 && k != 15) begin
            abort_at = k;
            break;
         end
      end
      if (abort_at >= 0) begin
         err_at = abort_at;
         len    = abort_at + 1;
      end else if (st_ok && (is_wr || is_rd) && match) begin
         rd_at = is_rd ? 13 : -1;
         wr_at = is_wr ? 31 : -1;
      end
      upd = st_ok && (is_wr || is_rd) && match && !(abort_at >= 0 && abort_at <= 13);
      RD_DATA = rd;
      for (int k = 0; k < len; k++) begin
         if (k == rst_at) begin
            do_reset();
            return;
         end
         MDIO_OUT = w[31-k];
         MDIO_OE  = (k < drop);
         lo_n = $urandom_range(1, 3);
         hi_n = $urandom_range(1, 3);
         repeat (lo_n) tick();
         MDC = 1'b1;
         tick();
         if (k == err_at) e_err = 1'b1;
         if (k == rd_at) e_rd = 1'b1;
         if (k == wr_at) begin
            e_wr    = 1'b1;
            e_wdata = w[15:0];
         end
         if (k == 13 && upd) e_reg = w[22:18];
         if (rd_at >= 0) begin
            if (k >= 15 && k < 31) begin
               e_oe = 1'b1;
               e_in = rd[30-k];
            end else if (k == 31) begin
               e_oe = 1'b0;
               e_in = 1'b0;
            end
         end
         repeat (hi_n - 1) tick();
         MDC = 1'b0;
      end
   endtask

   int          s_wr, s_rd, s_err, s_oe, s_cyc, drop, rst_at;
   logic [31:0] w;

   task automatic snap();
      s_wr = wr_cnt; s_rd = rd_cnt; s_err = err_cnt; s_oe = oe_bits; s_cyc = oe_cyc;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET = 1'b0; MDC = 1'b0; MDIO_OE = 1'b0; MDIO_OUT = 1'b0; RD_DATA = '0;
      e_in = 1'b0; e_oe = 1'b0; e_wr = 1'b0; e_rd = 1'b0; e_err = 1'b0;
      e_reg = '0; e_wdata = '0;
      #1 chk_en = 1'b1;
      repeat (3) @(posedge CLK);
      #2 RESET = 1'b1;
      tick();
      check("reset REG_ADDR", 32'(REG_ADDR), 32'h0);
      check("reset WR_DATA", 32'(WR_DATA), 32'h0);
      check("reset MDIO_IN_OE", 32'(MDIO_IN_OE), 32'h0);

      // Plain write, PHYAD=1 REGAD=1.
      snap();
      send_frame(32'h5086_ABCD, 32, 16'h0000, -1);
      tick(); tick();
      check("w1 strobes", 32'(wr_cnt - s_wr), 32'd1);
      check("w1 WR_DATA", 32'(last_wd), 32'h0000_ABCD);
      check("w1 REG_ADDR", 32'(REG_ADDR), 32'd1);
      check("w1 OE cycles", 32'(oe_cyc - s_cyc), 32'd0);

      // Read returning 0x1234.
      snap();
      send_frame(32'h6086_0000, 14, 16'h1234, -1);
      tick(); tick();
      check("r1 strobes", 32'(rd_cnt - s_rd), 32'd1);
      check("r1 REG_ADDR", 32'(REG_ADDR), 32'd1);
      check("r1 OE bits", 32'(oe_bits - s_oe), 32'd16);
      check("r1 serial", 32'(ser), 32'h0000_1234);

      // Foreign PHY address, then a valid write.
      snap();
      send_frame({2'b01, 2'b01, 5'd2, 5'd1, 2'b10, 16'h5555}, 32, 16'h0, -1);
      check("foreign events", 32'(wr_cnt - s_wr + rd_cnt - s_rd + err_cnt - s_err), 32'd0);
      send_frame({2'b01, 2'b01, 5'd1, 5'd4, 2'b10, 16'hBEEF}, 32, 16'h0, -1);
      tick(); tick();
      check("after foreign WR_DATA", 32'(last_wd), 32'h0000_BEEF);
      check("after foreign REG_ADDR", 32'(REG_ADDR), 32'd4);

      // Bad start code, bad opcode, then a read that must line up after the skipped bits.
      snap();
      send_frame({2'b00, 2'b01, 5'd1, 5'd9, 2'b10, 16'h0F0F}, 32, 16'h0, -1);
      tick(); tick();
      check("bad ST errors", 32'(err_cnt - s_err), 32'd1);
      snap();
      send_frame({2'b01, 2'b11, 5'd1, 5'd5, 2'b10, 16'h1111}, 32, 16'h0, -1);
      check("bad OP errors", 32'(err_cnt - s_err), 32'd1);
      check("bad OP REG_ADDR", 32'(REG_ADDR), 32'd4);
      send_frame({2'b01, 2'b10, 5'd1, 5'd5, 2'b10, 16'h0000}, 14, 16'h8001, -1);
      tick(); tick();
      check("post-skip read serial", 32'(ser), 32'h0000_8001);
      check("post-skip REG_ADDR", 32'(REG_ADDR), 32'd5);

      // Reset at bit 20 of a write, then a normal write.
      snap();
      send_frame({2'b01, 2'b01, 5'd1, 5'd6, 2'b10, 16'hCAFE}, 32, 16'h0, 20);
      check("rst no WR_STB", 32'(wr_cnt - s_wr), 32'd0);
      check("rst REG_ADDR", 32'(REG_ADDR), 32'h0);
      check("rst WR_DATA", 32'(WR_DATA), 32'h0);
      send_frame({2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'h00FF}, 32, 16'h0, -1);
      tick(); tick();
      check("post-rst WR_DATA", 32'(last_wd), 32'h0000_00FF);
      check("post-rst REG_ADDR", 32'(REG_ADDR), 32'd3);

      // Read immediately followed by write.
      snap();
      send_frame({2'b01, 2'b10, 5'd1, 5'd7, 2'b10, 16'h0000}, 14, 16'hA5C3, -1);
      send_frame({2'b01, 2'b01, 5'd1, 5'd8, 2'b10, 16'h1357}, 32, 16'h0, -1);
      tick(); tick();
      check("b2b read serial", 32'(ser), 32'h0000_A5C3);
      check("b2b strobes", 32'(wr_cnt - s_wr + rd_cnt - s_rd), 32'd2);
      check("b2b WR_DATA", 32'(last_wd), 32'h0000_1357);
      check("b2b REG_ADDR", 32'(REG_ADDR), 32'd8);

      for (int i = 0; i < 150; i++) begin
         w = $urandom;
         w[31:30] = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b01;
         if ($urandom_range(0, 3) != 0) w[27:23] = PHY;
         if ($urandom_range(0, 5) != 0) w[29:28] = 2'($urandom_range(1, 2));
         drop = (w[29:28] == 2'b10) ? 14 : 32;
         if ($urandom_range(0, 7) == 0) drop = $urandom_range(1, 31);
         rst_at = ($urandom_range(0, 29) == 0) ? $urandom_range(1, 30) : -1;
         send_frame(w, drop, 16'($urandom), rst_at);
         if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 5)) tick();
         if ($urandom_range(0, 5) == 0) idle_edge();
      end

      repeat (4) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
